alu_control_unit: RTL and testbench

Multi-cycle control FSM that drives the ALU datapath's control inputs (`cu_A`, `cu_B`, `opcode`, `RER`, `ir_operand`). It fetches 16-bit instructions from a synchronous instruction memory and decodes them into load / execute / store / jump sequences. It writes the ALU result register back to data memory on store. It sits between instruction memory, data memory and the ALU datapath, and is the initiator side of the datapath's control interface.

---
 rtl/alu_control_unit_pkg.sv | 53 +++++
 rtl/alu_control_unit_decode.sv | 48 ++++
 rtl/alu_control_unit.sv | 119 +++++++++++
 tb/tb_alu_control_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_control_unit_pkg.sv
// Shared opcode map, instruction-field positions, FSM state encoding and the
// control bundle produced by the decoder. Reused by the ALU datapath.
package alu_control_unit_pkg;

   localparam int unsigned INSTR_W   = 16;
   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned OPC_W     = 4;
   localparam int unsigned OPERAND_W = 8;
   localparam int unsigned IMM_BIT   = 11;
   localparam int unsigned SEL_W     = 2;

   typedef enum logic [OPC_W-1:0] {
      OP_NOP = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_AND = 4'h3,
      OP_OR  = 4'h4,
      OP_XOR = 4'h5,
      OP_LDA = 4'h8,
      OP_LDB = 4'h9,
      OP_STR = 4'hA,
      OP_JMP = 4'hC,
      OP_HLT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_MEM    = 3'd3,
      ST_LOAD   = 3'd4,
      ST_EXEC   = 3'd5,
      ST_WRITE  = 3'd6,
      ST_HALT   = 3'd7
   } state_e;

   // Operand-register load selects driven on cu_A / cu_B
   localparam logic [SEL_W-1:0] SEL_HOLD = 2'b00;
   localparam logic [SEL_W-1:0] SEL_DMEM = 2'b10;
   localparam logic [SEL_W-1:0] SEL_IMM  = 2'b11;

   typedef struct packed {
      logic [SEL_W-1:0]  cu_a;
      logic [SEL_W-1:0]  cu_b;
      logic              rer;
      logic              dmem_we;
      logic [ADDR_W-1:0] dmem_addr;
      logic              busy;
      logic              halted;
   } ctrl_t;

endpackage

// File: rtl/alu_control_unit_decode.sv
// Moore output decode: maps the current state and latched instruction fields
// to the datapath / data-memory control bundle.
//   state   in  : current FSM state
//   op      in  : ir opcode field
//   imm     in  : ir immediate flag
//   operand in  : ir operand field
//   ctrl    out : control bundle (combinational)
module cu_decode
   import alu_control_unit_pkg::*;
(
   input  state_e                 state,
   input  logic [OPC_W-1:0]       op,
   input  logic                   imm,
   input  logic [OPERAND_W-1:0]   operand,
   output ctrl_t                  ctrl
);

   logic [SEL_W-1:0] load_sel;

   always_comb begin
      ctrl     = '0;
      load_sel = imm ? SEL_IMM : SEL_DMEM;

      ctrl.busy   = (state != ST_IDLE) && (state != ST_HALT);
      ctrl.halted = (state == ST_HALT);

      case (state)
         ST_MEM: begin
            ctrl.dmem_addr = operand;
         end
         ST_LOAD: begin
            ctrl.dmem_addr = operand;
            // Only LDA/LDB reach LOAD, so anything not LDB targets A
            if (op == OP_LDB) ctrl.cu_b = load_sel;
            else              ctrl.cu_a = load_sel;
         end
         ST_EXEC: begin
            ctrl.rer = 1'b1;
         end
         ST_WRITE: begin
            ctrl.dmem_addr = operand;
            ctrl.dmem_we   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_control_unit.sv
// Multi-cycle control unit for the ALU datapath: fetches 16-bit instructions,
// decodes them into load / execute / store / jump sequences and drives the
// datapath control inputs as a Moore decode of state and ir.
//   clk, reset_alu_datapath : clock, async active-high reset
//   start                   : begin (IDLE) or resume (HALT) fetching
//   imem_addr / imem_data   : instruction memory (1-cycle sync read)
//   dmem_addr / dmem_we / dmem_wdata : data memory access, wdata = alu_r
//   alu_r                   : ALU result register R
//   ir_operand, opcode      : ir[7:0], ir[15:12]
//   cu_A, cu_B              : A / B register load selects
//   RER                     : result register enable
//   busy, halted            : status
module alu_control_unit
   import alu_control_unit_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset_alu_datapath,
   input  logic                   start,
   output logic [ADDR_W-1:0]      imem_addr,
   input  logic [INSTR_W-1:0]     imem_data,
   output logic [ADDR_W-1:0]      dmem_addr,
   output logic                   dmem_we,
   output logic [DATA_W-1:0]      dmem_wdata,
   input  logic [DATA_W-1:0]      alu_r,
   output logic [OPERAND_W-1:0]   ir_operand,
   output logic [SEL_W-1:0]       cu_A,
   output logic [SEL_W-1:0]       cu_B,
   output logic [OPC_W-1:0]       opcode,
   output logic                   RER,
   output logic                   busy,
   output logic                   halted
);

   state_e               state, state_nxt;
   logic [ADDR_W-1:0]    pc, pc_nxt;
   logic [INSTR_W-1:0]   ir, ir_nxt;
   ctrl_t                ctrl;

   // ir[10:8] are reserved in the instruction format and never decoded
   logic unused_rsvd_bits;
   assign unused_rsvd_bits = ^{ir[10:8], imem_data[10:8]};

   // State, program counter and instruction register
   always_ff @(posedge clk or posedge reset_alu_datapath) begin
      if (reset_alu_datapath) begin
         state <= ST_IDLE;
         pc    <= '0;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         ir    <= ir_nxt;
      end
   end

   // Next-state, pc and ir update; dispatch uses the word arriving from imem
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      ir_nxt    = ir;

      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            ir_nxt = imem_data;
            pc_nxt = pc + ADDR_W'(1);
            case (opcode_e'(imem_data[INSTR_W-1 -: OPC_W]))
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_nxt = ST_EXEC;
               OP_LDA, OP_LDB: state_nxt = imem_data[IMM_BIT] ? ST_LOAD : ST_MEM;
               OP_STR: state_nxt = ST_WRITE;
               OP_JMP: begin
                  pc_nxt    = imem_data[OPERAND_W-1:0];
                  state_nxt = ST_FETCH;
               end
               OP_HLT:  state_nxt = ST_HALT;
               default: state_nxt = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            state_nxt = ST_LOAD;
         end
         ST_LOAD, ST_EXEC, ST_WRITE: begin
            state_nxt = ST_FETCH;
         end
         ST_HALT: begin
            if (start) state_nxt = ST_FETCH;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   cu_decode u_decode (
      .state   (state),
      .op      (ir[INSTR_W-1 -: OPC_W]),
      .imm     (ir[IMM_BIT]),
      .operand (ir[OPERAND_W-1:0]),
      .ctrl    (ctrl)
   );

   assign imem_addr  = pc;
   assign dmem_addr  = ctrl.dmem_addr;
   assign dmem_we    = ctrl.dmem_we;
   assign dmem_wdata = alu_r;
   assign ir_operand = ir[OPERAND_W-1:0];
   assign opcode     = ir[INSTR_W-1 -: OPC_W];
   assign cu_A       = ctrl.cu_a;
   assign cu_B       = ctrl.cu_b;
   assign RER        = ctrl.rer;
   assign busy       = ctrl.busy;
   assign halted     = ctrl.halted;

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit: instruction/data memories and a
// small A/B/R datapath model surround the DUT; a table of single-instruction
// programs plus hand-written multi-cycle sequences, with data-memory writes
// checked against a scoreboard queue.
module tb_alu_control_unit;

   logic        clk;
   logic        reset_alu_datapath;
   logic        start;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic [7:0]  dmem_addr;
   logic        dmem_we;
   logic [7:0]  dmem_wdata;
   logic [7:0]  alu_r;
   logic [7:0]  ir_operand;
   logic [1:0]  cu_A;
   logic [1:0]  cu_B;
   logic [3:0]  opcode;
   logic        RER;
   logic        busy;
   logic        halted;

   int checks = 0;
   int errors = 0;

   logic [15:0] imem [256];
   logic [7:0]  dmem [256];
   bit          dmem_loaded = 1'b0;
   logic [7:0]  ra, rb, rr, dmem_rdata;
   logic [15:0] exp_wr [$];
   logic [15:0] mon_e;

   int          n_rer = 0, n_we = 0, n_cua = 0, n_cub = 0;
   logic [1:0]  last_cua = 2'b00, last_cub = 2'b00;

   alu_control_unit dut (
      .clk                (clk),
      .reset_alu_datapath (reset_alu_datapath),
      .start              (start),
      .imem_addr          (imem_addr),
      .imem_data          (imem_data),
      .dmem_addr          (dmem_addr),
      .dmem_we            (dmem_we),
      .dmem_wdata         (dmem_wdata),
      .alu_r              (alu_r),
      .ir_operand         (ir_operand),
      .cu_A               (cu_A),
      .cu_B               (cu_B),
      .opcode             (opcode),
      .RER                (RER),
      .busy               (busy),
      .halted             (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign alu_r = rr;

   function automatic logic [7:0] dmem_init(input int i);
      logic [7:0] v;
      v = 8'(i) ^ 8'h5A;
      if (i == 16) v = 8'hAA;
      return v;
   endfunction

   // Memories and A/B/R datapath model; dmem contents survive later resets
   always @(posedge clk or posedge reset_alu_datapath) begin
      if (reset_alu_datapath) begin
         ra <= 8'h00; rb <= 8'h00; rr <= 8'h00;
         imem_data  <= 16'h0000;
         dmem_rdata <= 8'h00;
         if (!dmem_loaded) begin
            for (int i = 0; i < 256; i++) dmem[i] <= dmem_init(i);
            dmem_loaded <= 1'b1;
         end
      end else begin
         imem_data  <= imem[imem_addr];
         dmem_rdata <= dmem[dmem_addr];
         if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
         if (cu_A == 2'b10) ra <= dmem_rdata;
         else if (cu_A == 2'b11) ra <= ir_operand;
         if (cu_B == 2'b10) rb <= dmem_rdata;
         else if (cu_B == 2'b11) rb <= ir_operand;
         if (RER) begin
            case (opcode)
               4'h1: rr <= ra + rb;
               4'h2: rr <= ra - rb;
               4'h3: rr <= ra & rb;
               4'h4: rr <= ra | rb;
               4'h5: rr <= ra ^ rb;
               default: rr <= rr;
            endcase
         end
      end
   end

   // Strobe counters and data-memory write scoreboard
   always @(negedge clk) begin
      if (RER) n_rer++;
      if (dmem_we) n_we++;
      if (cu_A != 2'b00) begin n_cua++; last_cua = cu_A; end
      if (cu_B != 2'b00) begin n_cub++; last_cub = cu_B; end
      if (dmem_we) begin
         checks++;
         if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL dmem_write: got addr=%02h data=%02h, required no write", dmem_addr, dmem_wdata);
         end else begin
            mon_e = exp_wr.pop_front();
            if ({dmem_addr, dmem_wdata} !== mon_e) begin
               errors++;
               $display("FAIL dmem_write: got addr/data=%04h, required %04h", {dmem_addr, dmem_wdata}, mon_e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic fill_imem();
      for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
   endtask

   task automatic do_reset();
      start = 1'b0;
      reset_alu_datapath = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset_alu_datapath = 1'b0;
   endtask

   // Count busy cycles until halted; optional start pulses while busy
   task automatic wait_halt(input bit pulse, output int bc);
      bit done;
      done = 1'b0;
      bc = 0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) bc++;
         if (halted) done = 1'b1;
         else if (pulse && (k == 3 || k == 7)) start = 1'b1;
      end
      check("halt_reached", 32'(done), 32'd1);
   endtask

   task automatic run_to_halt(input bit pulse, output int bc);
      @(negedge clk);
      start = 1'b1;
      wait_halt(pulse, bc);
   endtask

   typedef struct {
      logic [15:0] instr;
      int          busy;
      logic [7:0]  pc_end;
      int          rer;
      int          we;
      int          cua;
      int          cub;
      logic [1:0]  cua_v;
      logic [1:0]  cub_v;
   } vec_t;

   vec_t vecs [$];
   vec_t v;
   int   bc, b_rer, b_we, b_cua, b_cub;

   initial begin
      reset_alu_datapath = 1'b1;
      start = 1'b0;

      // instr, busy cycles incl. trailing HLT, pc at halt, strobe counts, select values
      vecs.push_back('{16'h0000, 4, 8'h02, 0, 0, 0, 0, 2'b00, 2'b00});
      vecs.push_back('{16'h7123, 4, 8'h02, 0, 0, 0, 0, 2'b00, 2'b00});
      vecs.push_back('{16'h6000, 4, 8'h02, 0, 0, 0, 0, 2'b00, 2'b00});
      vecs.push_back('{16'h1000, 5, 8'h02, 1, 0, 0, 0, 2'b00, 2'b00});
      vecs.push_back('{16'h5000, 5, 8'h02, 1, 0, 0, 0, 2'b00, 2'b00});
      vecs.push_back('{16'h8805, 5, 8'h02, 0, 0, 1, 0, 2'b11, 2'b00});
      vecs.push_back('{16'h9803, 5, 8'h02, 0, 0, 0, 1, 2'b00, 2'b11});
      vecs.push_back('{16'h8010, 6, 8'h02, 0, 0, 1, 0, 2'b10, 2'b00});
      vecs.push_back('{16'h9011, 6, 8'h02, 0, 0, 0, 1, 2'b00, 2'b10});
      vecs.push_back('{16'hA020, 5, 8'h02, 0, 1, 0, 0, 2'b00, 2'b00});
      vecs.push_back('{16'hC040, 4, 8'h41, 0, 0, 0, 0, 2'b00, 2'b00});
      vecs.push_back('{16'hC0FF, 4, 8'h00, 0, 0, 0, 0, 2'b00, 2'b00});
      vecs.push_back('{16'hF000, 2, 8'h01, 0, 0, 0, 0, 2'b00, 2'b00});

      // Reset state
      fill_imem();
      do_reset();
      @(negedge clk);
      check("rst_imem_addr", 32'(imem_addr), 32'h00);
      check("rst_dmem_addr", 32'(dmem_addr), 32'h00);
      check("rst_dmem_we", 32'(dmem_we), 32'h0);
      check("rst_dmem_wdata", 32'(dmem_wdata), 32'h00);
      check("rst_cu_A", 32'(cu_A), 32'h0);
      check("rst_cu_B", 32'(cu_B), 32'h0);
      check("rst_opcode", 32'(opcode), 32'h0);
      check("rst_ir_operand", 32'(ir_operand), 32'h00);
      check("rst_RER", 32'(RER), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_halted", 32'(halted), 32'h0);

      // Single-instruction programs, each followed by HLT
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         fill_imem();
         imem[0] = v.instr;
         do_reset();
         b_rer = n_rer; b_we = n_we; b_cua = n_cua; b_cub = n_cub;
         if (v.we != 0) exp_wr.push_back({v.instr[7:0], 8'h00});
         run_to_halt(1'b0, bc);
         check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(v.busy));
         check($sformatf("vec%0d_pc_end", i), 32'(imem_addr), 32'(v.pc_end));
         check($sformatf("vec%0d_rer_count", i), 32'(n_rer - b_rer), 32'(v.rer));
         check($sformatf("vec%0d_we_count", i), 32'(n_we - b_we), 32'(v.we));
         check($sformatf("vec%0d_cua_count", i), 32'(n_cua - b_cua), 32'(v.cua));
         check($sformatf("vec%0d_cub_count", i), 32'(n_cub - b_cub), 32'(v.cub));
         if (v.cua != 0) check($sformatf("vec%0d_cua_sel", i), 32'(last_cua), 32'(v.cua_v));
         if (v.cub != 0) check($sformatf("vec%0d_cub_sel", i), 32'(last_cub), 32'(v.cub_v));
      end

      // LDA #5, LDB #3, SUB, STR 0x20, HLT; start pulses while busy are ignored
      fill_imem();
      imem[0] = 16'h8805; imem[1] = 16'h9803; imem[2] = 16'h2000;
      imem[3] = 16'hA020; imem[4] = 16'hF000; imem[5] = 16'h0000;
      do_reset();
      exp_wr.push_back({8'h20, 8'h02});
      run_to_halt(1'b1, bc);
      check("prog_busy_cycles", 32'(bc), 32'd14);
      check("prog_halted", 32'(halted), 32'd1);
      check("prog_dmem20", 32'(dmem[8'h20]), 32'h02);
      check("prog_halt_pc", 32'(imem_addr), 32'h05);
      // Resume after HLT
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("resume_fetch_addr", 32'(imem_addr), 32'h05);
      check("resume_busy", 32'(busy), 32'd1);
      wait_halt(1'b0, bc);
      check("resume_busy_cycles", 32'(bc + 1), 32'd4);
      check("resume_halt_pc", 32'(imem_addr), 32'h07);

      // LDA from memory: MEM then LOAD, cu_A=10 for one cycle
      fill_imem();
      imem[0] = 16'h8010;
      do_reset();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("ldm_mem_dmem_addr", 32'(dmem_addr), 32'h10);
      check("ldm_mem_we", 32'(dmem_we), 32'h0);
      check("ldm_mem_cu_A", 32'(cu_A), 32'h0);
      @(negedge clk);
      check("ldm_load_dmem_addr", 32'(dmem_addr), 32'h10);
      check("ldm_load_cu_A", 32'(cu_A), 32'h2);
      check("ldm_load_cu_B", 32'(cu_B), 32'h0);
      @(negedge clk);
      check("ldm_after_cu_A", 32'(cu_A), 32'h0);
      check("ldm_a_value", 32'(ra), 32'hAA);
      wait_halt(1'b0, bc);

      // JMP to 0xFF, then pc wraps to 0x00
      fill_imem();
      imem[0] = 16'hC0FF; imem[8'hFF] = 16'h0000;
      do_reset();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("wrap_first_fetch", 32'(imem_addr), 32'h00);
      @(negedge clk);
      @(negedge clk);
      check("wrap_jmp_target", 32'(imem_addr), 32'hFF);
      check("wrap_opcode", 32'(opcode), 32'hC);
      check("wrap_ir_operand", 32'(ir_operand), 32'hFF);
      @(negedge clk);
      @(negedge clk);
      check("wrap_pc_zero", 32'(imem_addr), 32'h00);
      check("wrap_busy", 32'(busy), 32'd1);

      // Reset asserted during WRITE drops the store
      fill_imem();
      imem[0] = 16'h8807; imem[1] = 16'hA030;
      do_reset();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("wr_abort_we_before", 32'(dmem_we), 32'h1);
      check("wr_abort_addr_before", 32'(dmem_addr), 32'h30);
      #1 reset_alu_datapath = 1'b1;
      #1;
      check("wr_abort_we", 32'(dmem_we), 32'h0);
      check("wr_abort_busy", 32'(busy), 32'h0);
      check("wr_abort_pc", 32'(imem_addr), 32'h00);
      check("wr_abort_dmem_addr", 32'(dmem_addr), 32'h00);
      repeat (2) @(posedge clk);
      #2 reset_alu_datapath = 1'b0;
      check("wr_abort_dmem30", 32'(dmem[8'h30]), 32'h6A);
      exp_wr.push_back({8'h30, 8'h00});
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("restart_fetch_addr", 32'(imem_addr), 32'h00);
      wait_halt(1'b0, bc);
      check("restart_busy_cycles", 32'(bc + 1), 32'd8);

      check("pending_writes", 32'(exp_wr.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
